// File: rtl/multicycle_datapath_if.sv
// Control/memory bus between the multicycle control FSM, external memory and the datapath.
// master = controller/memory side, slave = datapath.
interface multicycle_datapath_if;
    logic        IorD;
    logic        MemRead;
    logic        MemWrite;
    logic        MemtoReg;
    logic        IRWrite;
    logic        PCSource;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic        RegWrite;
    logic        RegDst;
    logic        PCSel;
    logic [1:0]  ALUOp;
    logic [5:0]  Op;
    logic        Zero;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;
    logic [31:0] pc_out;

    modport master (
        output IorD, MemRead, MemWrite, MemtoReg, IRWrite, PCSource, ALUSrcA,
               ALUSrcB, RegWrite, RegDst, PCSel, ALUOp, mem_rdata,
        input  Op, Zero, mem_addr, mem_wdata, mem_read, mem_write, pc_out
    );

    modport slave (
        input  IorD, MemRead, MemWrite, MemtoReg, IRWrite, PCSource, ALUSrcA,
               ALUSrcB, RegWrite, RegDst, PCSel, ALUOp, mem_rdata,
        output Op, Zero, mem_addr, mem_wdata, mem_read, mem_write, pc_out
    );
endinterface

// File: rtl/multicycle_datapath.sv
// Datapath of the multicycle MIPS core: PC/IR/MDR/A/B/ALUOut, 32x32 register file, ALU and muxes.
// Driven cycle-by-cycle by the control FSM strobes; returns Op and Zero.
module multicycle_datapath #(
    parameter logic [31:0] PC_RESET          = 32'h0000_0000,
    parameter bit          RF_CLEAR_ON_RESET = 1'b1
) (
    input logic                  clk,
    input logic                  reset,
    multicycle_datapath_if.slave bus
);
    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_NONE} alu_ctl_e;

    logic [31:0] r_pc, r_ir, r_mdr, r_a, r_b, r_aluout;
    logic [31:0] r_rf [32];

    logic [31:0] w_sext, w_alu_a, w_alu_b, w_alu_res;
    logic [31:0] w_rs_data, w_rt_data, w_wdata;
    logic [4:0]  w_waddr;
    alu_ctl_e    w_alu_ctl;

    assign w_sext    = {{16{r_ir[15]}}, r_ir[15:0]};
    assign w_alu_a   = bus.ALUSrcA ? r_a : r_pc;
    assign w_rs_data = (r_ir[25:21] == 5'd0) ? 32'd0 : r_rf[r_ir[25:21]];
    assign w_rt_data = (r_ir[20:16] == 5'd0) ? 32'd0 : r_rf[r_ir[20:16]];
    assign w_waddr   = bus.RegDst ? r_ir[15:11] : r_ir[20:16];
    assign w_wdata   = bus.MemtoReg ? r_mdr : r_aluout;

    always_comb begin
        w_alu_b = r_b;
        case (bus.ALUSrcB)
            2'b00: w_alu_b = r_b;
            2'b01: w_alu_b = 32'd4;
            2'b10: w_alu_b = w_sext;
            2'b11: w_alu_b = {w_sext[29:0], 2'b00};
            default: w_alu_b = r_b;
        endcase
    end

    always_comb begin
        w_alu_ctl = ALU_ADD;
        case (bus.ALUOp)
            2'b01: w_alu_ctl = ALU_SUB;
            2'b10: begin
                case (r_ir[5:0])
                    6'b100000: w_alu_ctl = ALU_ADD;
                    6'b100010: w_alu_ctl = ALU_SUB;
                    6'b100100: w_alu_ctl = ALU_AND;
                    6'b100101: w_alu_ctl = ALU_OR;
                    6'b101010: w_alu_ctl = ALU_SLT;
                    default:   w_alu_ctl = ALU_NONE;
                endcase
            end
            default: w_alu_ctl = ALU_ADD;
        endcase
    end

    always_comb begin
        w_alu_res = 32'd0;
        case (w_alu_ctl)
            ALU_ADD: w_alu_res = w_alu_a + w_alu_b;
            ALU_SUB: w_alu_res = w_alu_a - w_alu_b;
            ALU_AND: w_alu_res = w_alu_a & w_alu_b;
            ALU_OR:  w_alu_res = w_alu_a | w_alu_b;
            ALU_SLT: w_alu_res = {31'd0, $signed(w_alu_a) < $signed(w_alu_b)};
            default: w_alu_res = 32'd0;
        endcase
    end

    // Reset blocks every load, including a strobed PC or register-file write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc     <= PC_RESET;
            r_ir     <= 32'd0;
            r_mdr    <= 32'd0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_aluout <= 32'd0;
        end else begin
            r_mdr    <= bus.mem_rdata;
            r_a      <= w_rs_data;
            r_b      <= w_rt_data;
            r_aluout <= w_alu_res;
            if (bus.IRWrite) r_ir <= bus.mem_rdata;
            if (bus.PCSel)   r_pc <= bus.PCSource ? r_aluout : w_alu_res;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if (RF_CLEAR_ON_RESET) begin
                for (int i = 0; i < 32; i++) r_rf[i] <= 32'd0;
            end
        end else if (bus.RegWrite && w_waddr != 5'd0) begin
            r_rf[w_waddr] <= w_wdata;
        end
    end

    // Zero follows the live ALU result so BEQ can resolve in the same cycle.
    assign bus.Zero      = (w_alu_res == 32'd0);
    assign bus.Op        = r_ir[31:26];
    assign bus.mem_addr  = bus.IorD ? r_aluout : r_pc;
    assign bus.mem_wdata = r_b;
    assign bus.mem_read  = bus.MemRead;
    assign bus.mem_write = bus.MemWrite;
    assign bus.pc_out    = r_pc;
endmodule
